// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and helpers for the demux_stream slice.
// Provides the default payload width and the select-width function.
package demux_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    // Select width for n channels, never narrower than one bit.
    function automatic int sel_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/demux_stream_if.sv
// demux_stream_if: bundles the demux_stream handshake and bus signals.
// master drives data/sel/valid/bcast/out_ready; slave drives the rest.
interface demux_stream_if
    import demux_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int NUM_CHANNELS = 4,
    parameter int SEL_WIDTH    = sel_width(NUM_CHANNELS)
);

    logic [DATA_WIDTH-1:0]              data;
    logic [SEL_WIDTH-1:0]               sel;
    logic                               valid;
    logic                               ready;
    logic                               bcast;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] out_data;
    logic [NUM_CHANNELS-1:0]            out_valid;
    logic [NUM_CHANNELS-1:0]            out_ready;
    logic                               err;

    modport master (
        output data, sel, valid, bcast, out_ready,
        input  ready, out_data, out_valid, err
    );

    modport slave (
        input  data, sel, valid, bcast, out_ready,
        output ready, out_data, out_valid, err
    );

endinterface

// File: rtl/demux_slot.sv
// demux_slot: one-entry register slice with valid/ready output side.
// Ports: clk_i, rst_ni, load_i, data_i, ready_i -> data_o, valid_o, free_o.
module demux_slot
    import demux_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  free_o
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // Free when empty or emptying on this edge.
    assign free_o = ~valid_q | ready_i;

    always_comb begin
        valid_d = valid_q & ~ready_i;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/demux_stream.sv
// demux_stream: routes one valid/ready stream to NUM_CHANNELS slotted outputs.
// Ports: clk_i, rst_ni, i, sel_i, valid_i, ready_o, data_o, valid_o,
//   ready_i, err_o (sticky out-of-range select); bcast_i when
//   DEMUX_STREAM_BROADCAST_EN is defined.
module demux_stream
    import demux_pkg::*;
#(
    parameter int  DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int  NUM_CHANNELS = 4,
    localparam int SEL_WIDTH    = sel_width(NUM_CHANNELS)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
`ifdef DEMUX_STREAM_BROADCAST_EN
    input  logic                               bcast_i,
`endif
    input  logic [DATA_WIDTH-1:0]              i,
    input  logic [SEL_WIDTH-1:0]               sel_i,
    input  logic                               valid_i,
    output logic                               ready_o,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_o,
    output logic [NUM_CHANNELS-1:0]            valid_o,
    input  logic [NUM_CHANNELS-1:0]            ready_i,
    output logic                               err_o
);

    logic [NUM_CHANNELS-1:0] sel_oh;
    logic [NUM_CHANNELS-1:0] free;
    logic [NUM_CHANNELS-1:0] load;
    logic                    sel_free;
    logic                    in_range;
    logic                    uni_ready;
    logic                    accept;
    logic                    err_q, err_d;

    // One-hot decode; an all-zero result marks an out-of-range select.
    always_comb begin
        sel_oh   = '0;
        sel_free = 1'b0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (sel_i == SEL_WIDTH'(k)) begin
                sel_oh[k] = 1'b1;
                sel_free  = free[k];
            end
        end
        in_range = |sel_oh;
    end

    // Out-of-range words are swallowed, so they always see ready.
    assign uni_ready = in_range ? sel_free : 1'b1;
    assign accept    = valid_i & ready_o;

`ifdef DEMUX_STREAM_BROADCAST_EN
    assign ready_o = bcast_i ? &free : uni_ready;

    always_comb begin
        load  = '0;
        err_d = err_q;
        if (accept) begin
            load  = bcast_i ? '1 : sel_oh;
            err_d = err_q | (~bcast_i & ~in_range);
        end
    end
`else
    assign ready_o = uni_ready;

    always_comb begin
        load  = '0;
        err_d = err_q;
        if (accept) begin
            load  = sel_oh;
            err_d = err_q | ~in_range;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_slot
        demux_slot #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_slot (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .load_i  (load[k]),
            .data_i  (i),
            .ready_i (ready_i[k]),
            .data_o  (data_o[k*DATA_WIDTH +: DATA_WIDTH]),
            .valid_o (valid_o[k]),
            .free_o  (free[k])
        );
    end

endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: directed self-checking bench for demux_stream.
// DUT a: 4 channels via demux_stream_if; DUT b: 3 channels for range checks.
module tb_demux_stream;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    demux_stream_if #(.DATA_WIDTH(16), .NUM_CHANNELS(4)) ifa ();

    logic [15:0] b_i;
    logic [1:0]  b_sel;
    logic        b_valid;
    logic        b_ready;
    logic [47:0] b_data;
    logic [2:0]  b_vo;
    logic [2:0]  b_ri;
    logic        b_err;
`ifdef DEMUX_STREAM_BROADCAST_EN
    logic        b_bcast;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    demux_stream #(.DATA_WIDTH(16), .NUM_CHANNELS(4)) u_a (
        .clk_i   (clk),
        .rst_ni  (rst_n),
`ifdef DEMUX_STREAM_BROADCAST_EN
        .bcast_i (ifa.bcast),
`endif
        .i       (ifa.data),
        .sel_i   (ifa.sel),
        .valid_i (ifa.valid),
        .ready_o (ifa.ready),
        .data_o  (ifa.out_data),
        .valid_o (ifa.out_valid),
        .ready_i (ifa.out_ready),
        .err_o   (ifa.err)
    );

    demux_stream #(.DATA_WIDTH(16), .NUM_CHANNELS(3)) u_b (
        .clk_i   (clk),
        .rst_ni  (rst_n),
`ifdef DEMUX_STREAM_BROADCAST_EN
        .bcast_i (b_bcast),
`endif
        .i       (b_i),
        .sel_i   (b_sel),
        .valid_i (b_valid),
        .ready_o (b_ready),
        .data_o  (b_data),
        .valid_o (b_vo),
        .ready_i (b_ri),
        .err_o   (b_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifa.valid = 1'b1;
        ifa.sel = 2'd0;
        ifa.data = 16'h1234;
        ifa.out_ready = 4'b0000;
        b_valid = 1'b1;
        b_sel = 2'd3;
        step();
        step();
        total++;
        if (ifa.out_valid !== 4'b0000) begin
            bad++;
            $display("FAIL reset_valid got=%b want=0000", ifa.out_valid);
        end
        total++;
        if (ifa.out_data !== 64'h0) begin
            bad++;
            $display("FAIL reset_data got=%h want=0", ifa.out_data);
        end
        total++;
        if (ifa.err !== 1'b0 || b_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_err got=%b%b want=00", ifa.err, b_err);
        end
        rst_n = 1'b1;
        ifa.valid = 1'b0;
        b_valid = 1'b0;
        step();
        total++;
        if (ifa.out_valid !== 4'b0000) begin
            bad++;
            $display("FAIL reset_noload got=%b want=0000", ifa.out_valid);
        end
    endtask

    task automatic test_unicast();
        ifa.data = 16'hA5A5;
        ifa.sel = 2'd2;
        ifa.valid = 1'b1;
        ifa.out_ready = 4'b1111;
        #1;
        total++;
        if (ifa.ready !== 1'b1) begin
            bad++;
            $display("FAIL uni_ready got=%b want=1", ifa.ready);
        end
        step();
        ifa.valid = 1'b0;
        total++;
        if (ifa.out_valid !== 4'b0100) begin
            bad++;
            $display("FAIL uni_valid got=%b want=0100", ifa.out_valid);
        end
        total++;
        if (ifa.out_data[32 +: 16] !== 16'hA5A5) begin
            bad++;
            $display("FAIL uni_data got=%h want=a5a5", ifa.out_data[32 +: 16]);
        end
        step();
        total++;
        if (ifa.out_valid !== 4'b0000) begin
            bad++;
            $display("FAIL uni_drain got=%b want=0000", ifa.out_valid);
        end
    endtask

    task automatic test_backpressure();
        ifa.out_ready = 4'b1101;
        ifa.sel = 2'd1;
        ifa.data = 16'h0011;
        ifa.valid = 1'b1;
        #1;
        total++;
        if (ifa.ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_first_ready got=%b want=1", ifa.ready);
        end
        step();
        ifa.data = 16'h0022;
        #1;
        total++;
        if (ifa.ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_stall_ready got=%b want=0", ifa.ready);
        end
        step();
        total++;
        if (ifa.out_valid[1] !== 1'b1 || ifa.out_data[16 +: 16] !== 16'h0011) begin
            bad++;
            $display("FAIL bp_hold got=%b/%h want=1/0011",
                     ifa.out_valid[1], ifa.out_data[16 +: 16]);
        end
        ifa.out_ready = 4'b1111;
        #1;
        total++;
        if (ifa.ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release_ready got=%b want=1", ifa.ready);
        end
        step();
        ifa.valid = 1'b0;
        total++;
        if (ifa.out_valid !== 4'b0010 || ifa.out_data[16 +: 16] !== 16'h0022) begin
            bad++;
            $display("FAIL bp_reload got=%b/%h want=0010/0022",
                     ifa.out_valid, ifa.out_data[16 +: 16]);
        end
        step();
        total++;
        if (ifa.out_valid !== 4'b0000) begin
            bad++;
            $display("FAIL bp_drain got=%b want=0000", ifa.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        ifa.out_ready = 4'b0001;
        ifa.sel = 2'd0;
        for (int n = 1; n <= 8; n++) begin
            ifa.data = 16'(n);
            ifa.valid = 1'b1;
            #1;
            total++;
            if (ifa.ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b_ready word=%0d got=%b want=1", n, ifa.ready);
            end
            step();
            total++;
            if (ifa.out_valid[0] !== 1'b1 || ifa.out_data[15:0] !== 16'(n)) begin
                bad++;
                $display("FAIL b2b_out got=%b/%h want=1/%h",
                         ifa.out_valid[0], ifa.out_data[15:0], 16'(n));
            end
        end
        ifa.valid = 1'b0;
        step();
        total++;
        if (ifa.out_valid !== 4'b0000) begin
            bad++;
            $display("FAIL b2b_drain got=%b want=0000", ifa.out_valid);
        end
    endtask

    task automatic test_out_of_range();
        b_ri = 3'b111;
        b_sel = 2'd3;
        b_i = 16'h1048;
        b_valid = 1'b1;
        #1;
        total++;
        if (b_ready !== 1'b1) begin
            bad++;
            $display("FAIL oor_ready got=%b want=1", b_ready);
        end
        step();
        b_valid = 1'b0;
        total++;
        if (b_err !== 1'b1) begin
            bad++;
            $display("FAIL oor_err got=%b want=1", b_err);
        end
        total++;
        if (b_vo !== 3'b000) begin
            bad++;
            $display("FAIL oor_valid got=%b want=000", b_vo);
        end
        repeat (10) step();
        total++;
        if (b_err !== 1'b1) begin
            bad++;
            $display("FAIL oor_sticky got=%b want=1", b_err);
        end
        b_sel = 2'd2;
        b_i = 16'h0777;
        b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        total++;
        if (b_vo !== 3'b100 || b_data[32 +: 16] !== 16'h0777) begin
            bad++;
            $display("FAIL oor_inrange got=%b/%h want=100/0777",
                     b_vo, b_data[32 +: 16]);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total++;
        if (b_err !== 1'b0 || b_vo !== 3'b000) begin
            bad++;
            $display("FAIL oor_reset got=%b/%b want=0/000", b_err, b_vo);
        end
    endtask

`ifdef DEMUX_STREAM_BROADCAST_EN
    task automatic test_broadcast();
        ifa.bcast = 1'b0;
        ifa.out_ready = 4'b0111;
        ifa.sel = 2'd3;
        ifa.data = 16'h0BEE;
        ifa.valid = 1'b1;
        step();
        ifa.bcast = 1'b1;
        ifa.data = 16'h00FF;
        #1;
        total++;
        if (ifa.ready !== 1'b0) begin
            bad++;
            $display("FAIL bc_stall got=%b want=0", ifa.ready);
        end
        step();
        total++;
        if (ifa.out_valid !== 4'b1000 || ifa.out_data[48 +: 16] !== 16'h0BEE) begin
            bad++;
            $display("FAIL bc_hold got=%b/%h want=1000/0bee",
                     ifa.out_valid, ifa.out_data[48 +: 16]);
        end
        ifa.out_ready = 4'b1111;
        #1;
        total++;
        if (ifa.ready !== 1'b1) begin
            bad++;
            $display("FAIL bc_ready got=%b want=1", ifa.ready);
        end
        step();
        ifa.valid = 1'b0;
        ifa.bcast = 1'b0;
        total++;
        if (ifa.out_valid !== 4'b1111 || ifa.out_data !== 64'h00FF00FF00FF00FF) begin
            bad++;
            $display("FAIL bc_load got=%b/%h want=1111/00ff00ff00ff00ff",
                     ifa.out_valid, ifa.out_data);
        end
        step();
        total++;
        if (ifa.out_valid !== 4'b0000) begin
            bad++;
            $display("FAIL bc_drain got=%b want=0000", ifa.out_valid);
        end
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        ifa.data = '0;
        ifa.sel = '0;
        ifa.valid = 1'b0;
        ifa.bcast = 1'b0;
        ifa.out_ready = '0;
        b_i = '0;
        b_sel = '0;
        b_valid = 1'b0;
        b_ri = '0;
`ifdef DEMUX_STREAM_BROADCAST_EN
        b_bcast = 1'b0;
`endif
        test_reset();
        test_unicast();
        test_backpressure();
        test_back_to_back();
        test_out_of_range();
`ifdef DEMUX_STREAM_BROADCAST_EN
        test_broadcast();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
